// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between NREQ
//   byte producers. Each byte is presented on uart_data and held by raising
//   uart_send. The UART signals acceptance by raising busy. After every
//   attempt, uart_send is held low for GAP cycles so the UART's
//   baud-sampled send input can re-arm.
//
// Ports
//   clk_xtal    in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [NREQ]    request per requester, held until ack
//   req_data    in   [8*NREQ]  byte of requester i at [8i+7:8i]
//   ack         out  [NREQ]    one-cycle pulse when the UART accepts a byte
//   grant       out  [NREQ]    one-hot owner from SEND through GAP
//   uart_send   out            to UART send
//   uart_data   out  [8]       to UART DataOut, latched at grant
//   uart_busy   in             from UART busy (asynchronous)
//   timeout_err out            one-cycle pulse when SEND times out
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535,
    parameter int GAP     = 1024
) (
    input  logic              clk_xtal,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              uart_send,
    output logic [7:0]        uart_data,
    input  logic              uart_busy,
    output logic              timeout_err
);
    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0]     TO_CNT   = 16'(TIMEOUT);
    localparam logic [15:0]     GAP_END  = 16'(GAP - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_GAP} state_t;

    state_t          state_q, state_d;
    logic            busy_meta_q, busy_s_q;
    logic [15:0]     cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            send_q, send_d;
    logic [7:0]      data_q, data_d;
    logic            to_q, to_d;

    logic            any_req;
    logic [IW-1:0]   winner;
    logic [IW:0]     idx;
    logic [NREQ-1:0] win_onehot;
    logic [7:0]      data_sel;

    // Two-flop synchronizer; busy_s_q is the only view of uart_busy.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= uart_busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // Round-robin search starting just after the last owner, wrapping mod NREQ.
    always_comb begin
        any_req = 1'b0;
        winner  = last_q;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, last_q} + (IW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!any_req && req[idx[IW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
        data_sel           = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) data_sel = req_data[8*i +: 8];
        end
    end

    // Shared SEND-timeout / GAP counter; saturates instead of wrapping.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        send_d  = send_q;
        data_d  = data_q;
        ack_d   = '0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Busy while idle means the UART is receiving; hold off.
                if (!busy_s_q && any_req) begin
                    data_d  = data_sel;
                    grant_d = win_onehot;
                    last_d  = winner;
                    send_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (busy_s_q) begin
                    send_d         = 1'b0;
                    ack_d[last_q]  = 1'b1;
                    state_d        = S_WAIT_DONE;
                end else if (cnt_q == TO_CNT) begin
                    // The requester keeps req. The pointer has already
                    // moved past it, so other requesters get a turn first.
                    send_d  = 1'b0;
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_s_q) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= 8'h00;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            data_q  <= data_d;
            to_q    <= to_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign uart_send   = send_q;
    assign uart_data   = data_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT=100, GAP=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 100;
    localparam int GAP     = 16;

    logic            clk_xtal = 1'b0;
    logic            rst_n    = 1'b0;
    logic [NREQ-1:0] req      = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] grant;
    logic            uart_send;
    logic [7:0]      uart_data;
    logic            uart_busy = 1'b0;
    logic            timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk_xtal    (clk_xtal),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant       (grant),
        .uart_send   (uart_send),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_xtal = ~clk_xtal;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_xtal);
    endtask

    // Wait for uart_send high; n = number of falling edges waited, -1 if none.
    task automatic wait_send(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk_xtal);
            if (uart_send === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_xtal);
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        uart_busy = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        @(negedge clk_xtal);
        rst_n     = 1'b0;
        req       = 4'b1111;
        req_data  = 32'hDEADBEEF;
        uart_busy = 1'b1;
        step(3);
        vectors++;
        if ({uart_send, uart_data, ack, grant, timeout_err} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got send=%b data=%h ack=%b grant=%b to=%b, want all zero",
                     uart_send, uart_data, ack, grant, timeout_err);
        end
        req = '0; uart_busy = 1'b0;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        int n;
        int bad;
        do_reset();
        req_data[7:0] = 8'h55;
        req           = 4'b0001;
        wait_send(20, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d edges, want 1", n);
        end
        vectors++;
        if (grant !== 4'b0001 || uart_data !== 8'h55) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%b data=%h, want 0001/55", grant, uart_data);
        end
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            step(1);
            if (uart_send !== 1'b1 || ack !== 4'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL single_hold: %0d cycles with send low or ack set, want 0", bad);
        end
        uart_busy = 1'b1;
        step(2);
        vectors++;
        if (ack !== 4'b0 || uart_send !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ack_early: got ack=%b send=%b, want 0000/1", ack, uart_send);
        end
        step(1);
        vectors++;
        if (ack !== 4'b0001 || uart_send !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b send=%b, want 0001/0", ack, uart_send);
        end
        req = '0;
        step(1);
        vectors++;
        if (ack !== 4'b0) begin
            miscompares++;
            $display("FAIL single_ack_pulse: got ack=%b, want 0000", ack);
        end
        step(49);
        uart_busy     = 1'b0;
        req_data[7:0] = 8'h66;
        req           = 4'b0001;
        // busy falls: 2 sync edges, 1 edge into GAP, GAP edges, 1 edge to send.
        wait_send(GAP + 20, n);
        vectors++;
        if (n !== GAP + 4) begin
            miscompares++;
            $display("FAIL single_gap: next send after %0d edges, want %0d", n, GAP + 4);
        end
        vectors++;
        if (uart_data !== 8'h66 || grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_second: got data=%h grant=%b, want 66/0001", uart_data, grant);
        end
    endtask

    task automatic test_fairness();
        int n;
        int nack;
        logic [NREQ-1:0] ack_seen;
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_data = 32'hA3A2A1A0;
        req      = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            exp_g = 4'b0001 << (g % 4);
            wait_send(GAP + 20, n);
            vectors++;
            if (n !== ((g == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL fair_latency[%0d]: got %0d edges, want %0d", g, n, (g == 0) ? 1 : 2);
            end
            vectors++;
            if (grant !== exp_g || uart_data !== (8'hA0 + 8'(g % 4))) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got grant=%b data=%h, want %b/%h",
                         g, grant, uart_data, exp_g, 8'hA0 + 8'(g % 4));
            end
            step(4);
            uart_busy = 1'b1;
            nack = 0; ack_seen = '0;
            for (int i = 0; i < 12; i++) begin
                step(1);
                if (ack !== 4'b0) begin nack++; ack_seen = ack; end
            end
            uart_busy = 1'b0;
            for (int i = 0; i < GAP + 2; i++) begin
                step(1);
                if (ack !== 4'b0) begin nack++; ack_seen = ack; end
            end
            vectors++;
            if (nack != 1 || ack_seen !== exp_g) begin
                miscompares++;
                $display("FAIL fair_ack[%0d]: got %0d acks last=%b, want 1 ack %b", g, nack, ack_seen, exp_g);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int bad;
        do_reset();
        req_data = 32'h0000_2211;
        req      = 4'b0011;
        wait_send(20, n);
        vectors++;
        if (n !== 1 || grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_first_grant: got n=%0d grant=%b, want 1/0001", n, grant);
        end
        bad = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step(1);
            if (timeout_err !== 1'b0 || uart_send !== 1'b1 || ack !== 4'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL to_early: %0d bad cycles before timeout, want 0", bad);
        end
        step(1);
        vectors++;
        if (timeout_err !== 1'b1 || uart_send !== 1'b0 || ack !== 4'b0) begin
            miscompares++;
            $display("FAIL to_pulse: got to=%b send=%b ack=%b, want 1/0/0000", timeout_err, uart_send, ack);
        end
        step(1);
        vectors++;
        if (timeout_err !== 1'b0 || ack !== 4'b0) begin
            miscompares++;
            $display("FAIL to_pulse_width: got to=%b ack=%b, want 0/0000", timeout_err, ack);
        end
        wait_send(GAP + 20, n);
        vectors++;
        if (n !== GAP || grant !== 4'b0010 || uart_data !== 8'h22) begin
            miscompares++;
            $display("FAIL to_next_grant: got n=%0d grant=%b data=%h, want %0d/0010/22",
                     n, grant, uart_data, GAP);
        end
    endtask

    task automatic test_rx_holdoff();
        int bad;
        do_reset();
        uart_busy = 1'b1;
        step(5);
        req_data[23:16] = 8'h77;
        req             = 4'b0100;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (uart_send !== 1'b0 || grant !== 4'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rx_hold: %0d cycles with send/grant active, want 0", bad);
        end
        uart_busy = 1'b0;
        step(2);
        vectors++;
        if (uart_send !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_release_early: got send=%b, want 0", uart_send);
        end
        step(1);
        vectors++;
        if (uart_send !== 1'b1 || grant !== 4'b0100 || uart_data !== 8'h77) begin
            miscompares++;
            $display("FAIL rx_release: got send=%b grant=%b data=%h, want 1/0100/77",
                     uart_send, grant, uart_data);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        req_data = 32'h4400_3311;
        req      = 4'b0010;
        wait_send(20, n);
        uart_busy = 1'b1;
        step(3);
        vectors++;
        if (ack !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_ack: got ack=%b, want 0010", ack);
        end
        req = 4'b1001;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (uart_send !== 1'b0 || grant !== 4'b0 || ack !== 4'b0 || uart_data !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_async: got send=%b grant=%b ack=%b data=%h, want 0/0000/0000/00",
                     uart_send, grant, ack, uart_data);
        end
        uart_busy = 1'b0;
        @(negedge clk_xtal);
        rst_n = 1'b1;
        wait_send(20, n);
        vectors++;
        if (n !== 1 || grant !== 4'b0001 || uart_data !== 8'h11) begin
            miscompares++;
            $display("FAIL mid_priority: got n=%0d grant=%b data=%h, want 1/0001/11", n, grant, uart_data);
        end
    endtask

    task automatic test_withdraw();
        int n;
        do_reset();
        req_data[15:8] = 8'h3C;
        req            = 4'b0010;
        wait_send(20, n);
        step(1);
        req            = 4'b0000;
        req_data[15:8] = 8'hFF;
        step(3);
        vectors++;
        if (uart_data !== 8'h3C || grant !== 4'b0010 || uart_send !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_hold: got data=%h grant=%b send=%b, want 3C/0010/1", uart_data, grant, uart_send);
        end
        uart_busy = 1'b1;
        step(3);
        vectors++;
        if (ack !== 4'b0010 || uart_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL wd_ack: got ack=%b data=%h, want 0010/3C", ack, uart_data);
        end
        uart_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_rx_holdoff();
        test_reset_mid();
        test_withdraw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single UART transmitter between NREQ byte-producing requesters (CPU store path, debug monitor, etc.). It sits between the requesters and the UART `send`/`DataOut`/`busy` handshake. It sequences each byte through the UART's level-sensitive, baud-clock-sampled `send` input and guarantees the `send`-low gap the UART needs to re-arm. All logic runs on the crystal clock; `uart_busy` is treated as asynchronous.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 65535: clk_xtal cycles to wait in SEND for `uart_busy` before abandoning the attempt. 16-bit counter.
- GAP, 1024: clk_xtal cycles `uart_send` stays low after a transfer. Must exceed 2 baud-clock periods.

- clk_xtal  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  requester i holds high, with stable data, until `ack[i]`.
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i].
- ack  out  NREQ  one-cycle pulse: byte of requester i accepted by UART.
- grant  out  NREQ  one-hot current owner, SEND through GAP; 0 in IDLE.
- uart_send  out  1  to UART `send`.
- uart_data  out  8  to UART `DataOut`; registered, stable while `grant`≠0.
- uart_busy  in  1  from UART `busy`; async.
- timeout_err  out  1  one-cycle pulse on SEND timeout.

## Operation
- `uart_busy` passes through a 2-flop synchronizer to busy_s. No other logic uses raw `uart_busy`.
- The round-robin pointer `last` holds the index of the last owner. Reset value is NREQ-1, so requester 0 has first priority. The search order is last+1, last+2, … modulo NREQ.
- States:
  - IDLE: if busy_s=0 and any req is set, pick the winner. Latch its byte into `uart_data`, set `grant`, set `last`=winner, `uart_send`←1, clear the counter, and go to SEND. If busy_s=1 (UART receiving), wait.
  - SEND: if busy_s=1, `uart_send`←0, pulse `ack[owner]`, and go to WAIT_DONE. Otherwise, when the counter reaches TIMEOUT, `uart_send`←0, pulse `timeout_err`, send no ack, and go to GAP. The requester keeps `req`, and the pointer has already advanced past it.
  - WAIT_DONE: when busy_s=0, clear the counter and go to GAP.
  - GAP: count to GAP-1 with `uart_send`=0, then clear `grant` and go to IDLE.
- busy_s rising while in SEND is always taken as acceptance. A receive start coinciding with the attempt is indistinguishable from acceptance. This is an accepted limitation.
- A requester that drops `req` after grant does not abort the transfer; `ack` still pulses.
- A change of `req_data` after grant has no effect, because the byte is already latched.
- Counter width is 16 bits. It never wraps, saturating at its terminal count.

## Timing
- Reset values: `uart_send`=0, `uart_data`=0, `ack`=0, `grant`=0, `timeout_err`=0, state IDLE, `last`=NREQ-1, synchronizer=0. Reset mid-transfer drops `uart_send` immediately (async). The interrupted byte is neither acked nor retried by this block.
- `req` high in IDLE → `uart_send`=1 and `grant` valid on the next edge (1-cycle arbitration latency).
- `ack` pulses the cycle after busy_s is sampled high, which is 3 edges after `uart_busy` rises. `uart_send` falls in the same cycle as `ack`.
- Minimum spacing between consecutive `uart_send` rises is transfer time + GAP + 1 cycle.
- When multiple requests arrive in the same cycle, only one is granted. The others are served in pointer order, and no requester is granted twice while another is pending.

## Test plan
- Single requester: req[0]=1, byte 0x55, UART stub raises busy 300 cycles after send and holds it for 2000 cycles → uart_data=0x55, ack[0] pulses 3 cycles after busy rise, send low ≥ GAP cycles before the next grant.
- Fairness: req=4'b1111 held continuously with bytes 0xA0..0xA3 → grant order 0,1,2,3,0…, with exactly one ack per grant.
- Timeout: busy stub never rises, TIMEOUT=100 → timeout_err pulses at cycle 101 after send, no ack, next grant goes to a different pending requester.
- RX-busy hold-off: uart_busy=1 before req[2] rises → uart_send stays 0 until 2 cycles after busy falls, then grant[2].
- Reset mid-transfer: rst_n low during WAIT_DONE → uart_send, grant, and ack all 0 immediately. After release, requester 0 has priority.
- Req withdrawal: req[1] dropped one cycle after grant with data changed to 0xFF → uart_data keeps the original byte and ack[1] still pulses.
